// File: rtl/accelerator_state_matrix_transmitter.sv
// accelerator_state_matrix_transmitter
//   Holds a host-loaded matrix (DEPTH = 2**ADDRESS_SIZE words) and streams it
//   one element per cycle with I/J enable strobes.
//   Optional build macro: ACCELERATOR_STATE_TRANSPOSE_EN
//     defined   -> column-major walk (emits the transpose, shape SIZE_J x SIZE_I)
//     undefined -> row-major walk
module accelerator_state_matrix_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic                    WRITE_ENABLE,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    // Counters and latched sizes only need to hold 0..DEPTH once the
    // overflow check has passed.
    localparam int CW    = ADDRESS_SIZE + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        i_q, i_d;
    logic [CW-1:0]        j_q, j_d;
    logic [CW-1:0]        size_i_q, size_i_d;
    logic [CW-1:0]        size_j_q, size_j_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 i_en_q, i_en_d;
    logic                 j_en_q, j_en_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic                 mem_wr_en;

    // Launch-time size classification
    logic                 size_zero;
    logic                 size_i_big, size_j_big;
    logic [2*CW-1:0]      size_prod;
    logic                 size_over;
    logic [ADDRESS_SIZE-1:0] rd_addr;
    logic                 last_i, last_j;

    // Classify the requested shape: a product can only fit if each side
    // already fits, so the narrow product is exact whenever it is consulted.
    always_comb begin
        size_zero  = (SIZE_I_IN == '0) || (SIZE_J_IN == '0);
        size_i_big = SIZE_I_IN > DATA_SIZE'(DEPTH);
        size_j_big = SIZE_J_IN > DATA_SIZE'(DEPTH);
        size_prod  = {{CW{1'b0}}, SIZE_I_IN[CW-1:0]} * {{CW{1'b0}}, SIZE_J_IN[CW-1:0]};
        size_over  = !size_zero &&
                     (size_i_big || size_j_big || (size_prod > (2*CW)'(DEPTH)));
    end

    // Read address and end-of-dimension flags for the element being emitted;
    // the true index is below DEPTH so modulo-DEPTH arithmetic is exact.
    always_comb begin
        rd_addr = i_q[ADDRESS_SIZE-1:0] * size_j_q[ADDRESS_SIZE-1:0]
                + j_q[ADDRESS_SIZE-1:0];
        last_i  = (i_q == size_i_q - CW'(1));
        last_j  = (j_q == size_j_q - CW'(1));
    end

    // Host writes land only while idle; anything during a stream is dropped.
    always_comb begin
        mem_wr_en = WRITE_ENABLE && (state_q == S_IDLE);
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequencer and output regs
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        size_i_d   = size_i_q;
        size_j_d   = size_j_q;
        data_out_d = data_out_q;
        i_en_d     = 1'b0;
        j_en_d     = 1'b0;
        ready_d    = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    size_i_d = SIZE_I_IN[CW-1:0];
                    size_j_d = SIZE_J_IN[CW-1:0];
                    i_d      = '0;
                    j_d      = '0;
                    if (size_over) begin
                        error_d = 1'b1;
                    end else if (size_zero) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                data_out_d = mem_q[rd_addr];
                j_en_d     = 1'b1;
`ifdef ACCELERATOR_STATE_TRANSPOSE_EN
                // Column-major: i is the inner index, a new output row starts at i==0.
                i_en_d = (i_q == '0);
                if (last_i) begin
                    i_d = '0;
                    j_d = j_q + CW'(1);
                end else begin
                    i_d = i_q + CW'(1);
                end
`else
                // Row-major: j is the inner index, a new row starts at j==0.
                i_en_d = (j_q == '0);
                if (last_j) begin
                    j_d = '0;
                    i_d = i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
`endif
                if (last_i && last_j) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            size_i_q   <= '0;
            size_j_q   <= '0;
            data_out_q <= '0;
            i_en_q     <= 1'b0;
            j_en_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            size_i_q   <= size_i_d;
            size_j_q   <= size_j_d;
            data_out_q <= data_out_d;
            i_en_q     <= i_en_d;
            j_en_q     <= j_en_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    // Matrix storage, cleared by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (mem_wr_en) begin
            mem_q[WRITE_ADDRESS] <= WRITE_DATA;
        end
    end

    assign READY             = ready_q;
    assign ERROR             = error_q;
    assign DATA_OUT_I_ENABLE = i_en_q;
    assign DATA_OUT_J_ENABLE = j_en_q;
    assign DATA_OUT          = data_out_q;

endmodule

// File: tb/tb_accelerator_state_matrix_transmitter.sv
// Directed bench for accelerator_state_matrix_transmitter (both builds).
module tb_accelerator_state_matrix_transmitter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic        ERROR;
    logic        WRITE_ENABLE;
    logic [3:0]  WRITE_ADDRESS;
    logic [63:0] WRITE_DATA;
    logic [63:0] SIZE_I_IN;
    logic [63:0] SIZE_J_IN;
    logic        DATA_OUT_I_ENABLE;
    logic        DATA_OUT_J_ENABLE;
    logic [63:0] DATA_OUT;

    int total  = 0;
    int passed = 0;

    accelerator_state_matrix_transmitter #(.DATA_SIZE(64), .ADDRESS_SIZE(4)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .START             (START),
        .READY             (READY),
        .ERROR             (ERROR),
        .WRITE_ENABLE      (WRITE_ENABLE),
        .WRITE_ADDRESS     (WRITE_ADDRESS),
        .WRITE_DATA        (WRITE_DATA),
        .SIZE_I_IN         (SIZE_I_IN),
        .SIZE_J_IN         (SIZE_J_IN),
        .DATA_OUT_I_ENABLE (DATA_OUT_I_ENABLE),
        .DATA_OUT_J_ENABLE (DATA_OUT_J_ENABLE),
        .DATA_OUT          (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [63:0] si, input logic [63:0] sj);
        SIZE_I_IN = si;
        SIZE_J_IN = sj;
        START     = 1'b1;
        tick();
        START     = 1'b0;
    endtask

    logic [63:0] exp_data [6];
    logic        exp_ien  [6];
    logic        row_ien;

    initial begin
`ifdef ACCELERATOR_STATE_TRANSPOSE_EN
        exp_data = '{64'd10, 64'd13, 64'd11, 64'd14, 64'd12, 64'd15};
        exp_ien  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        row_ien  = 1'b1;
`else
        exp_data = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd14, 64'd15};
        exp_ien  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        row_ien  = 1'b0;
`endif
        RST = 1'b0; START = 1'b0; WRITE_ENABLE = 1'b0;
        WRITE_ADDRESS = '0; WRITE_DATA = '0; SIZE_I_IN = '0; SIZE_J_IN = '0;
        tick(); tick();
        check("rst_data", DATA_OUT, 64'd0);
        check("rst_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        check("rst_ready_err", {62'd0, READY, ERROR}, 64'd0);
        RST = 1'b1;
        tick();

        // Test 1: load 10..15, stream 2x3
        for (int k = 0; k < 6; k++) begin
            WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 4'(k); WRITE_DATA = 64'(10 + k);
            tick();
        end
        WRITE_ENABLE = 1'b0;
        launch(64'd2, 64'd3);
        check("t1_latency_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        for (int e = 0; e < 6; e++) begin
            tick();
            check($sformatf("t1_data%0d", e), DATA_OUT, exp_data[e]);
            check($sformatf("t1_jen%0d", e), {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
            check($sformatf("t1_ien%0d", e), {63'd0, DATA_OUT_I_ENABLE}, {63'd0, exp_ien[e]});
            check($sformatf("t1_ready%0d", e), {63'd0, READY}, 64'd0);
        end
        tick();
        check("t1_ready", {63'd0, READY}, 64'd1);
        check("t1_done_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        check("t1_hold_data", DATA_OUT, exp_data[5]);
        tick();
        check("t1_ready_pulse", {63'd0, READY}, 64'd0);

        // Test 2: 4x5 overflows, plus a huge size that would truncate to a small product
        launch(64'd4, 64'd5);
        check("t2_error", {63'd0, ERROR}, 64'd1);
        check("t2_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        tick();
        check("t2_error_pulse", {63'd0, ERROR}, 64'd0);
        check("t2_ready", {63'd0, READY}, 64'd0);
        check("t2_idle_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        launch(64'h8000_0000_0000_0001, 64'd1);
        check("t2_wide_error", {63'd0, ERROR}, 64'd1);
        tick();
        check("t2_wide_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);

        // Test 3: zero rows -> straight to DONE
        launch(64'd0, 64'd3);
        check("t3_jen0", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        check("t3_ready0", {63'd0, READY}, 64'd0);
        tick();
        check("t3_ready", {63'd0, READY}, 64'd1);
        check("t3_jen1", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        check("t3_err", {63'd0, ERROR}, 64'd0);
        tick();
        check("t3_ready_pulse", {63'd0, READY}, 64'd0);

        // Test 4: START and WRITE during RUN are ignored
        launch(64'd1, 64'd3);
        START = 1'b1; WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 4'd0; WRITE_DATA = 64'd99;
        tick();
        START = 1'b0; WRITE_ENABLE = 1'b0;
        check("t4_d0", DATA_OUT, 64'd10);
        check("t4_ien0", {63'd0, DATA_OUT_I_ENABLE}, 64'd1);
        tick();
        check("t4_d1", DATA_OUT, 64'd11);
        check("t4_ien1", {63'd0, DATA_OUT_I_ENABLE}, {63'd0, row_ien});
        tick();
        check("t4_d2", DATA_OUT, 64'd12);
        tick();
        check("t4_ready", {63'd0, READY}, 64'd1);
        tick();
        check("t4_no_restart", {62'd0, READY, DATA_OUT_J_ENABLE}, 64'd0);
        launch(64'd1, 64'd1);
        tick();
        check("t4_old_mem0", DATA_OUT, 64'd10);

        // Simultaneous START and WRITE in IDLE: stream sees the new word
        tick();
        WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 4'd0; WRITE_DATA = 64'd55;
        launch(64'd1, 64'd1);
        WRITE_ENABLE = 1'b0;
        tick();
        check("t4_wr_start", DATA_OUT, 64'd55);
        tick();

        // Test 5: reset in the middle of a 4x4 stream
        launch(64'd4, 64'd4);
        tick(); tick(); tick(); tick();
        check("t5_e3_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
        RST = 1'b0;
        #1;
        check("t5_rst_data", DATA_OUT, 64'd0);
        check("t5_rst_jen", {62'd0, DATA_OUT_J_ENABLE, DATA_OUT_I_ENABLE}, 64'd0);
        tick(); tick();
        check("t5_no_ready", {63'd0, READY}, 64'd0);
        RST = 1'b1;
        tick();
        check("t5_post_ready", {63'd0, READY}, 64'd0);
        launch(64'd1, 64'd1);
        tick();
        check("t5_cleared_mem", DATA_OUT, 64'd0);
        check("t5_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
        tick();
        check("t5_ready", {63'd0, READY}, 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
